hamming_secded_decoder: RTL and testbench
=========================================

# hamming_secded_decoder

Parametrised, pipelined extended-Hamming SECDED decoder with valid/ready streaming. Accepts one 2^R-bit codeword per cycle, computes the syndrome and overall parity, and corrects single-bit errors. Flags uncorrectable double-bit errors and keeps saturating error counters. It replaces the fixed [7,4] single-error decoder on the memory and link receive paths. It also adds double-error detection, backpressure, a detect-only mode and error statistics.

## Interface
- R, default 3: Hamming check bits, legal range 3..6. Derived values: N = 2^R codeword bits and K = 2^R-1-R data bits. The default gives [8,4].
- CNT_W, default 16: width of each error counter.
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  in  1  codeword on in_codeword is valid.
- in_ready  out  1  decoder can accept a beat this cycle.
- in_codeword  in  N  bit 0 is overall parity. Bits 1..N-1 are Hamming positions: powers of two hold check bits, other positions hold data bits in ascending order (data bit 0 at position 3).
- correct_en  in  1  1 = correct single errors; 0 = detect only. Sampled with each accepted beat.
- clr_cnt  in  1  synchronous clear of both counters.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  K  decoded data.
- out_syndrome  out  R  raw syndrome of the beat.
- out_single_err  out  1  single error detected.
- out_double_err  out  1  uncorrectable error detected.
- corr_count  out  CNT_W  number of beats delivered with single_err=1; saturates.
- uncorr_count  out  CNT_W  number of beats delivered with double_err=1; saturates.

## Operation
- Syndrome s = XOR of indices i (1..N-1) where codeword[i]=1. Overall parity p = XOR of all N bits.
- s=0, p=0: clean. Data is extracted unchanged and no flags are set.
- p=1: single error, so single_err=1. If s≠0 and correct_en=1, invert bit s before data extraction. If s=0, the error is in bit 0 and data is unaffected.
- s≠0, p=0: double error, so double_err=1. Data is extracted raw and uncorrected.
- correct_en=0: flags and syndrome behave as above, but no bit is ever inverted.
- single_err and double_err are never both 1.
- Counters increment only on an output handshake (out_valid & out_ready) whose flag is set. They hold at 2^CNT_W-1. clr_cnt has priority over an increment in the same cycle.

## Timing
- Two-stage pipeline. Stage 1 registers the codeword, s, p and correct_en. Stage 2 registers the corrected data and flags.
- Latency: a beat accepted in cycle t appears on out_valid in cycle t+2 when there is no backpressure.
- Throughput is one beat per cycle.
- Each stage advances when its output register is empty or being consumed. in_ready = !s1_valid | s1_advance. in_ready is combinational from out_ready, with no bubble.
- With out_valid=1 and out_ready=0, all output fields hold stable until the handshake.
- in_ready deasserts only once both stages are full.
- No beat is ever lost or duplicated.
- Reset: in_ready=0 while rst_n=0, then 1 from the first cycle after release. out_valid, out_data, out_syndrome, both flags and both counters are all 0.
- Reset mid-stream: in-flight beats are discarded and the counters clear.

## Structure
- Package hamming_pkg holds functions for N/K from R, position-is-check, and data-bit-to-position mapping. The same package serves the matching encoder.
- One sub-module, hamming_syndrome: combinational, parametrised on R, produces s and p. It is shared with the future scrubber.
- Everything else lives in the top module.

## Test plan
All scenarios use R=3.
- Clean codeword: 8'hAA with correct_en=1 gives data 4'b1011, s=0, no flags, output two cycles later.
- Single error at bit 5: 8'h8A gives data 4'b1011, s=5, single_err=1, and corr_count increments by 1.
- Error in the parity bit: 8'hAB gives data 4'b1011, s=0, single_err=1.
- Double error: 8'hE2 (bits 3 and 6 flipped) gives s=5, double_err=1, raw data 4'b1110, and uncorr_count increments by 1.
- Detect-only: 8'h8A with correct_en=0 gives raw data 4'b1001 and single_err=1.
- Backpressure and counters:
  - Stream 20 single-error beats while toggling out_ready randomly. All 20 must be delivered in order, and in_ready must drop only when both stages are full.
  - With CNT_W=4, corr_count must saturate at 15.
  - clr_cnt asserted in a counting cycle gives 0.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared helpers for the extended-Hamming SECDED encoder/decoder family.
// Position 0 is overall parity; powers of two carry check bits.
package hamming_pkg;

  function automatic int calc_n(input int r);
    return 1 << r;
  endfunction

  function automatic int calc_k(input int r);
    return (1 << r) - 1 - r;
  endfunction

  function automatic logic is_check_pos(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Data bits fill the non-power-of-two positions in ascending order from 3.
  function automatic int data_pos(input int idx);
    int res;
    int cnt;
    res = 0;
    cnt = 0;
    for (int p = 3; p < 128; p++) begin
      if (!is_check_pos(p)) begin
        if (cnt == idx) res = p;
        cnt++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity generator for a 2^R-bit codeword.
// Shared between the decoder and the scrubber.
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter int R = 3
) (
  input  logic [calc_n(R)-1:0] codeword_i,
  output logic [R-1:0]         syndrome_o,
  output logic                 parity_o
);

  localparam int N = calc_n(R);

  always_comb begin
    syndrome_o = '0;
    for (int i = 1; i < N; i++) begin
      if (codeword_i[i]) syndrome_o = syndrome_o ^ R'(i);
    end
    parity_o = ^codeword_i;
  end

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined SECDED decoder with valid/ready flow control,
// detect-only mode and saturating error counters.
module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter int R     = 3,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [calc_n(R)-1:0] in_codeword,
  input  logic                 correct_en,
  input  logic                 clr_cnt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [calc_k(R)-1:0] out_data,
  output logic [R-1:0]         out_syndrome,
  output logic                 out_single_err,
  output logic                 out_double_err,
  output logic [CNT_W-1:0]     corr_count,
  output logic [CNT_W-1:0]     uncorr_count
);

  localparam int N = calc_n(R);
  localparam int K = calc_k(R);

  logic [R-1:0] syn;
  logic         par;

  hamming_syndrome #(.R(R)) u_syndrome (
    .codeword_i (in_codeword),
    .syndrome_o (syn),
    .parity_o   (par)
  );

  logic         s1_valid_q;
  logic [N-1:0] s1_cw_q;
  logic [R-1:0] s1_syn_q;
  logic         s1_par_q;
  logic         s1_cen_q;

  logic         out_valid_q;
  logic [K-1:0] out_data_q;
  logic [R-1:0] out_syn_q;
  logic         out_single_q;
  logic         out_double_q;

  logic         s2_free;
  logic         s1_advance;
  logic         fire;

  assign s2_free    = !out_valid_q || out_ready;
  assign s1_advance = s1_valid_q && s2_free;
  assign in_ready   = rst_n && (!s1_valid_q || s1_advance);
  assign fire       = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_cw_q    <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
      s1_cen_q   <= 1'b0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_cw_q  <= in_codeword;
        s1_syn_q <= syn;
        s1_par_q <= par;
        s1_cen_q <= correct_en;
      end
    end
  end

  logic [N-1:0] cw_fix;
  logic [K-1:0] data_d;
  logic         single_d;
  logic         double_d;

  // A zero syndrome with odd parity flips bit 0, which carries no data.
  always_comb begin
    single_d = s1_par_q;
    double_d = !s1_par_q && (s1_syn_q != '0);
    cw_fix   = s1_cw_q;
    if (single_d && s1_cen_q) cw_fix[s1_syn_q] = ~s1_cw_q[s1_syn_q];
  end

  for (genvar j = 0; j < K; j++) begin : g_extract
    assign data_d[j] = cw_fix[data_pos(j)];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_syn_q    <= '0;
      out_single_q <= 1'b0;
      out_double_q <= 1'b0;
    end else if (s2_free) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q   <= data_d;
        out_syn_q    <= s1_syn_q;
        out_single_q <= single_d;
        out_double_q <= double_d;
      end
    end
  end

  logic [CNT_W-1:0] corr_q, corr_d;
  logic [CNT_W-1:0] uncorr_q, uncorr_d;

  always_comb begin
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    if (clr_cnt) begin
      corr_d   = '0;
      uncorr_d = '0;
    end else if (fire) begin
      if (out_single_q && (corr_q != '1))   corr_d   = corr_q + 1'b1;
      if (out_double_q && (uncorr_q != '1)) uncorr_d = uncorr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else begin
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_syndrome   = out_syn_q;
  assign out_single_err = out_single_q;
  assign out_double_err = out_double_q;
  assign corr_count     = corr_q;
  assign uncorr_count   = uncorr_q;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Scoreboard bench for the R=3 SECDED decoder with 4-bit counters.
module tb_hamming_secded_decoder;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_codeword = '0;
  logic          correct_en = 1'b1;
  logic          clr_cnt = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [3:0]    out_data;
  logic [2:0]    out_syndrome;
  logic          out_single_err;
  logic          out_double_err;
  logic [CW-1:0] corr_count;
  logic [CW-1:0] uncorr_count;

  hamming_secded_decoder #(.R(3), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_codeword    (in_codeword),
    .correct_en     (correct_en),
    .clr_cnt        (clr_cnt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_syndrome   (out_syndrome),
    .out_single_err (out_single_err),
    .out_double_err (out_double_err),
    .corr_count     (corr_count),
    .uncorr_count   (uncorr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic [2:0] s;
    logic       se;
    logic       de;
    logic       lat;
    int         t;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rdy_mode = 0;
  logic mon_en = 1'b0;
  logic [CW-1:0] exp_corr = '0;
  logic [CW-1:0] exp_unc = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else if (rdy_mode == 0) out_ready = 1'b1;
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: counters, in_ready, liveness and scoreboard at each falling edge.
  initial forever begin
    exp_t e;
    logic f_s, f_d;
    @(negedge clk);
    f_s = 1'b0;
    f_d = 1'b0;
    if (rst_n && mon_en) begin
      check("corr_count", int'(corr_count), int'(exp_corr));
      check("uncorr_count", int'(uncorr_count), int'(exp_unc));
      check("in_ready", int'(in_ready), int'(!(sb.size() == 2 && !out_ready)));
      if (sb.size() > 0 && (cyc - sb[0].t) >= 2)
        check("out_valid_live", int'(out_valid), 1);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = sb.pop_front();
          check("data", int'(out_data), int'(e.d));
          check("syndrome", int'(out_syndrome), int'(e.s));
          check("single_err", int'(out_single_err), int'(e.se));
          check("double_err", int'(out_double_err), int'(e.de));
          if (e.lat) check("latency", cyc - e.t, 2);
          f_s = e.se;
          f_d = e.de;
        end
      end
      if (clr_cnt) begin
        exp_corr = '0;
        exp_unc  = '0;
      end else begin
        if (f_s && exp_corr != '1) exp_corr = exp_corr + 1'b1;
        if (f_d && exp_unc != '1)  exp_unc  = exp_unc + 1'b1;
      end
    end
  end

  task automatic send(input logic [7:0] cw, input logic cen, input logic [3:0] d,
                      input logic [2:0] s, input logic se, input logic de, input logic lat);
    exp_t e;
    int tries;
    logic acc;
    in_valid = 1'b1;
    in_codeword = cw;
    correct_en = cen;
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 200) begin
      @(negedge clk);
      acc = in_ready;
      e.t = cyc;
      tries++;
      @(posedge clk);
      if (acc) begin
        e.d = d; e.s = s; e.se = se; e.de = de; e.lat = lat;
        sb.push_back(e);
      end
      #1;
    end
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int tries;
    tries = 0;
    while (sb.size() > 0 && tries < 500) begin
      @(posedge clk);
      tries++;
    end
    if (sb.size() > 0) check("drain_timeout", sb.size(), 0);
    #1;
  endtask

  initial begin
    logic [7:0] bases [3];
    logic [3:0] bdata [3];
    logic [7:0] one;
    int tries;
    bases = '{8'h00, 8'hAA, 8'hFF};
    bdata = '{4'h0, 4'hB, 4'hF};

    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_flags", int'({out_single_err, out_double_err, out_syndrome}), 0);
    check("rst_counters", int'({corr_count, uncorr_count}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Directed vectors, full throughput, no backpressure.
    send(8'hAA, 1'b1, 4'b1011, 3'd0, 1'b0, 1'b0, 1'b1);
    send(8'h8A, 1'b1, 4'b1011, 3'd5, 1'b1, 1'b0, 1'b1);
    send(8'hAB, 1'b1, 4'b1011, 3'd0, 1'b1, 1'b0, 1'b1);
    send(8'hE2, 1'b1, 4'b1110, 3'd5, 1'b0, 1'b1, 1'b1);
    send(8'h8A, 1'b0, 4'b1001, 3'd5, 1'b1, 1'b0, 1'b1);
    drain();
    @(negedge clk);
    check("directed_corr", int'(corr_count), 3);
    check("directed_uncorr", int'(uncorr_count), 1);
    @(posedge clk);
    #1;

    // 20 single-error beats under random backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 20; i++) begin
      one = 8'h01 << (i % 8);
      send(bases[i % 3] ^ one, 1'b1, bdata[i % 3], 3'(i % 8), 1'b1, 1'b0, 1'b0);
    end
    rdy_mode = 0;
    drain();
    @(negedge clk);
    check("sat_corr", int'(corr_count), 15);
    check("sat_uncorr", int'(uncorr_count), 1);
    @(posedge clk);
    #1;

    // Clear in the same cycle as a counting handshake.
    rdy_mode = 2;
    out_ready = 1'b0;
    send(8'h8A, 1'b1, 4'b1011, 3'd5, 1'b1, 1'b0, 1'b1);
    tries = 0;
    while (!out_valid && tries < 10) begin
      @(posedge clk);
      #1;
      tries++;
    end
    check("clr_setup_valid", int'(out_valid), 1);
    clr_cnt = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    @(negedge clk);
    check("clr_corr", int'(corr_count), 0);
    check("clr_uncorr", int'(uncorr_count), 0);
    rdy_mode = 0;
    drain();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
